// File: rtl/char_pkg.sv
// Shared types for the character-physics engine: motion and sequencer
// state encodings plus the keypad bit positions.
package char_pkg;

   typedef enum logic [1:0] {
      M_GROUND,
      M_JUMP,
      M_FALL
   } motion_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_X,
      S_WT_X,
      S_RD_Y,
      S_WT_Y,
      S_DONE
   } seq_e;

   localparam int MOV_UP    = 3;
   localparam int MOV_DOWN  = 2;
   localparam int MOV_LEFT  = 1;
   localparam int MOV_RIGHT = 0;

endpackage

// File: rtl/tick_gen.sv
// Movement-tick divider: counts 0..DIV-1 and pulses tick for one cycle on
// each wrap. Pause freezes the count and suppresses the pulse.
module tick_gen #(
   parameter int DIV = 200000
) (
   input  logic sys_clk,
   input  logic rst_n,
   input  logic pause,
   output logic tick
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;
   logic          wrap;

   assign wrap = (cnt_q == CNT_LAST);

   always_comb begin
      // NOTE: every _d gets a default before any branch, so no path can infer a latch.
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (!pause) begin
         tick_d = wrap;
         cnt_d  = wrap ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values; blocking here would race.
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/char_motion.sv
// Character-physics engine: per tick, probes the blocking map for one X and
// one Y candidate and commits each move only when the target pixel is free.
module char_motion
   import char_pkg::*;
#(
   parameter int X_W      = 10,
   parameter int Y_W      = 10,
   parameter int ADDR_W   = 19,
   parameter int MAP_W    = 960,
   parameter int X_MIN    = 0,
   parameter int X_MAX    = 960,
   parameter int Y_MIN    = 0,
   parameter int Y_MAX    = 400,
   parameter int X_INIT   = 244,
   parameter int Y_INIT   = 400,
   parameter int TICK_DIV = 200000,
   parameter int STEP     = 1,
   parameter int JUMP_LEN = 48,
   parameter int MEM_LAT  = 1
) (
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic [3:0]        mov,
   input  logic              pause,
   output logic [X_W-1:0]    char_X,
   output logic [Y_W-1:0]    char_Y,
   output logic [ADDR_W-1:0] blk_addr,
   output logic              blk_rd,
   input  logic              blk_data,
   output logic              on_ground,
   output logic              jumping,
   output logic              step_done
);

   localparam int JC_W = $clog2(JUMP_LEN + 1);
   localparam logic [X_W:0]      X_LO     = (X_W + 1)'(X_MIN);
   localparam logic [X_W:0]      X_SPAN   = (X_W + 1)'(X_MAX - X_MIN);
   localparam logic [Y_W:0]      Y_LO     = (Y_W + 1)'(Y_MIN);
   localparam logic [Y_W:0]      Y_SPAN   = (Y_W + 1)'(Y_MAX - Y_MIN);
   localparam logic [X_W:0]      STEP_X   = (X_W + 1)'(STEP);
   localparam logic [Y_W:0]      STEP_Y   = (Y_W + 1)'(STEP);
   localparam logic [1:0]        LAT_LAST = 2'(MEM_LAT - 1);
   localparam logic [JC_W-1:0]   JC_LAST  = JC_W'(JUMP_LEN - 1);

   function automatic logic [ADDR_W-1:0] map_addr(input logic [Y_W:0] y, input logic [X_W:0] x);
      return ADDR_W'(y) * ADDR_W'(MAP_W) + ADDR_W'(x);
   endfunction

   seq_e              seq_q, seq_d;
   motion_e           motion_q, motion_d;
   logic [X_W-1:0]    x_q, x_d;
   logic [Y_W-1:0]    y_q, y_d;
   logic [X_W:0]      cx_q, cx_d;
   logic [Y_W:0]      cy_q, cy_d;
   logic [JC_W-1:0]   jc_q, jc_d;
   logic [1:0]        wt_q, wt_d;
   logic              up_q, up_d;
   logic              blk_rd_q, blk_rd_d;
   logic [ADDR_W-1:0] blk_addr_q, blk_addr_d;
   logic              step_done_q, step_done_d;

   logic              tick;
   logic [X_W:0]      cx_new;
   logic [Y_W:0]      cy_new;
   logic [X_W-1:0]    x_next;
   logic              x_ok, y_ok, lat_done;
   logic              unused_down;

   assign unused_down = mov[MOV_DOWN];

   tick_gen #(.DIV(TICK_DIV)) u_tick (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .pause   (pause),
      .tick    (tick)
   );

   always_comb begin
      seq_d       = seq_q;
      motion_d    = motion_q;
      x_d         = x_q;
      y_d         = y_q;
      cx_d        = cx_q;
      cy_d        = cy_q;
      jc_d        = jc_q;
      wt_d        = wt_q;
      up_d        = up_q;
      blk_addr_d  = blk_addr_q;
      blk_rd_d    = 1'b0;
      step_done_d = 1'b0;

      // Both or neither direction keys still probe the current X.
      cx_new = {1'b0, x_q};
      if (mov[MOV_LEFT] && !mov[MOV_RIGHT])
         cx_new = {1'b0, x_q} - STEP_X;
      else if (mov[MOV_RIGHT] && !mov[MOV_LEFT])
         cx_new = {1'b0, x_q} + STEP_X;

      // Offset-then-compare in W+1 bits: an underflowed candidate wraps high and fails.
      x_ok     = ((cx_q - X_LO) <= X_SPAN) && !blk_data;
      x_next   = x_ok ? cx_q[X_W-1:0] : x_q;
      cy_new   = (motion_q == M_JUMP) ? {1'b0, y_q} - STEP_Y : {1'b0, y_q} + STEP_Y;
      y_ok     = ((cy_q - Y_LO) <= Y_SPAN) && !blk_data;
      lat_done = (wt_q == LAT_LAST);

      case (seq_q)
         S_IDLE: if (tick) begin
            cx_d       = cx_new;
            blk_addr_d = map_addr({1'b0, y_q}, cx_new);
            blk_rd_d   = 1'b1;
            seq_d      = S_RD_X;
         end
         S_RD_X: begin
            wt_d  = '0;
            seq_d = S_WT_X;
         end
         S_WT_X: if (lat_done) begin
            x_d        = x_next;
            cy_d       = cy_new;
            blk_addr_d = map_addr(cy_new, {1'b0, x_next});
            blk_rd_d   = 1'b1;
            seq_d      = S_RD_Y;
         end else begin
            wt_d = wt_q + 1'b1;
         end
         S_RD_Y: begin
            wt_d  = '0;
            up_d  = mov[MOV_UP];
            seq_d = S_WT_Y;
         end
         S_WT_Y: if (lat_done) begin
            case (motion_q)
               M_GROUND: if (y_ok) begin
                  y_d      = cy_q[Y_W-1:0];
                  motion_d = M_FALL;
               end else if (up_q) begin
                  motion_d = M_JUMP;
                  jc_d     = '0;
               end
               M_JUMP: if (y_ok) begin
                  y_d  = cy_q[Y_W-1:0];
                  jc_d = jc_q + 1'b1;
                  if (jc_q == JC_LAST) motion_d = M_FALL;
               end else begin
                  motion_d = M_FALL;
               end
               default: if (y_ok) begin
                  y_d = cy_q[Y_W-1:0];
               end else begin
                  motion_d = M_GROUND;
               end
            endcase
            step_done_d = 1'b1;
            seq_d       = S_DONE;
         end else begin
            wt_d = wt_q + 1'b1;
         end
         S_DONE:  seq_d = S_IDLE;
         default: seq_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_q       <= S_IDLE;
         motion_q    <= M_GROUND;
         x_q         <= X_W'(X_INIT);
         y_q         <= Y_W'(Y_INIT);
         cx_q        <= '0;
         cy_q        <= '0;
         jc_q        <= '0;
         wt_q        <= '0;
         up_q        <= 1'b0;
         blk_rd_q    <= 1'b0;
         blk_addr_q  <= '0;
         step_done_q <= 1'b0;
      end else begin
         seq_q       <= seq_d;
         motion_q    <= motion_d;
         x_q         <= x_d;
         y_q         <= y_d;
         cx_q        <= cx_d;
         cy_q        <= cy_d;
         jc_q        <= jc_d;
         wt_q        <= wt_d;
         up_q        <= up_d;
         blk_rd_q    <= blk_rd_d;
         blk_addr_q  <= blk_addr_d;
         step_done_q <= step_done_d;
      end
   end

   assign char_X    = x_q;
   assign char_Y    = y_q;
   assign blk_addr  = blk_addr_q;
   assign blk_rd    = blk_rd_q;
   assign step_done = step_done_q;
   assign on_ground = (motion_q == M_GROUND);
   assign jumping   = (motion_q == M_JUMP);

endmodule

// File: tb/tb_char_motion.sv
// Bench for char_motion: a per-tick behavioural model of the movement rules
// plus a sparse blocking map behind a latency-accurate RAM stand-in.
module tb_char_motion;

   localparam int MAP_W    = 960;
   localparam int X_MIN    = 0;
   localparam int X_MAX    = 960;
   localparam int Y_MIN    = 0;
   localparam int Y_MAX    = 400;
   localparam int X_INIT   = 244;
   localparam int Y_INIT   = 400;
   localparam int JUMP_LEN = 48;
   localparam int TICK_DIV = 16;

   localparam logic [3:0] K_NONE  = 4'b0000;
   localparam logic [3:0] K_RIGHT = 4'b0001;
   localparam logic [3:0] K_LEFT  = 4'b0010;
   localparam logic [3:0] K_UP    = 4'b1000;

   localparam int MD_GROUND = 0;
   localparam int MD_JUMP   = 1;
   localparam int MD_FALL   = 2;

   logic        sys_clk = 1'b0;
   logic        rst_n, rst3_n, pause;
   logic [3:0]  mov, mov3;
   logic [9:0]  char_X, char_Y, char_X3, char_Y3;
   logic [18:0] blk_addr, blk_addr3;
   logic        blk_rd, blk_rd3, blk_data, blk_data3;
   logic        on_ground, jumping, step_done;
   logic        on_ground3, jumping3, step_done3;

   int n_checks = 0;
   int n_errors = 0;

   bit   blk [int];
   bit   all_blk3 = 1'b0;
   logic pipe1 = 1'b0;
   logic [2:0] pipe3 = 3'b000;

   int mx, my, mj, mmode;
   int a_x, a_y;

   always #5 sys_clk = ~sys_clk;

   // Synchronous map RAMs: latency 1 for the main instance, 3 for the second.
   always @(posedge sys_clk) begin
      pipe1 <= blk_rd && blk.exists(int'(blk_addr));
      pipe3 <= {pipe3[1:0], blk_rd3 && all_blk3};
   end
   assign blk_data  = pipe1;
   assign blk_data3 = pipe3[2];

   char_motion #(.TICK_DIV(TICK_DIV)) u_dut (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .mov       (mov),
      .pause     (pause),
      .char_X    (char_X),
      .char_Y    (char_Y),
      .blk_addr  (blk_addr),
      .blk_rd    (blk_rd),
      .blk_data  (blk_data),
      .on_ground (on_ground),
      .jumping   (jumping),
      .step_done (step_done)
   );

   char_motion #(.TICK_DIV(TICK_DIV), .MEM_LAT(3)) u_lat3 (
      .sys_clk   (sys_clk),
      .rst_n     (rst3_n),
      .mov       (mov3),
      .pause     (1'b0),
      .char_X    (char_X3),
      .char_Y    (char_Y3),
      .blk_addr  (blk_addr3),
      .blk_rd    (blk_rd3),
      .blk_data  (blk_data3),
      .on_ground (on_ground3),
      .jumping   (jumping3),
      .step_done (step_done3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic bit can_enter(input int x, input int y);
      return x >= X_MIN && x <= X_MAX && y >= Y_MIN && y <= Y_MAX && !blk.exists(y * MAP_W + x);
   endfunction

   task automatic model_reset();
      mx = X_INIT; my = Y_INIT; mmode = MD_GROUND; mj = 0;
   endtask

   task automatic model_step(input logic [3:0] k);
      int dx;
      dx = 0;
      if (k[1] && !k[0]) dx = -1;
      else if (k[0] && !k[1]) dx = 1;
      if (can_enter(mx + dx, my)) mx = mx + dx;
      case (mmode)
         MD_GROUND: if (can_enter(mx, my + 1)) begin
            my = my + 1; mmode = MD_FALL;
         end else if (k[3]) begin
            mmode = MD_JUMP; mj = 0;
         end
         MD_JUMP: if (can_enter(mx, my - 1)) begin
            my = my - 1; mj = mj + 1;
            if (mj == JUMP_LEN) mmode = MD_FALL;
         end else begin
            mmode = MD_FALL;
         end
         default: if (can_enter(mx, my + 1)) my = my + 1;
                  else mmode = MD_GROUND;
      endcase
   endtask

   task automatic compare_model();
      check("char_X", 32'(char_X), mx);
      check("char_Y", 32'(char_Y), my);
      check("on_ground", 32'(on_ground), 32'(mmode == MD_GROUND));
      check("jumping", 32'(jumping), 32'(mmode == MD_JUMP));
   endtask

   task automatic do_reset();
      @(negedge sys_clk);
      rst_n = 1'b0;
      mov   = K_NONE;
      #2;
      model_reset();
      check("rst_char_X", 32'(char_X), X_INIT);
      check("rst_char_Y", 32'(char_Y), Y_INIT);
      check("rst_on_ground", 32'(on_ground), 1);
      check("rst_jumping", 32'(jumping), 0);
      check("rst_blk_rd", 32'(blk_rd), 0);
      check("rst_blk_addr", 32'(blk_addr), 0);
      check("rst_step_done", 32'(step_done), 0);
      @(negedge sys_clk);
      rst_n = 1'b1;
   endtask

   // One full tick: apply keys, wait for step_done, compare against the model.
   task automatic run_tick(input logic [3:0] k, input bit timing);
      int rd_first, rd_second, rd_cnt, done_at;
      mov = k;
      model_step(k);
      rd_first = -1; rd_second = -1; rd_cnt = 0; done_at = -1;
      for (int c = 0; c < 4 * TICK_DIV; c++) begin
         @(posedge sys_clk); #1;
         if (blk_rd) begin
            rd_cnt++;
            if (rd_first < 0) begin rd_first = c; a_x = int'(blk_addr); end
            else if (rd_second < 0) begin rd_second = c; a_y = int'(blk_addr); end
         end
         if (step_done) begin done_at = c; break; end
      end
      if (done_at < 0) begin
         check("step_done_timeout", 0, 1);
      end else begin
         compare_model();
         if (timing) begin
            check("rd_gap", rd_second - rd_first, 2);
            check("done_latency", done_at - rd_first, 4);
            check("rd_pulses", rd_cnt, 2);
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int got, cnt, rd_at, done_at;
      rst_n = 1'b1; rst3_n = 1'b1; pause = 1'b0; mov = K_NONE; mov3 = K_NONE;
      #2;
      rst3_n = 1'b0;
      do_reset();
      rst3_n = 1'b1;

      // Right move on a free map, with schedule and address checks.
      run_tick(K_RIGHT, 1'b1);
      check("addr_x_probe", a_x, 400 * MAP_W + 245);
      check("addr_y_probe", a_y, 401 * MAP_W + 245);
      run_tick(K_RIGHT, 1'b1);
      run_tick(K_RIGHT, 1'b0);
      check("right_3_ticks", 32'(char_X), 247);

      // Left wall at X_MIN: no wrap past zero.
      repeat (250) run_tick(K_LEFT, 1'b0);
      check("wall_left_x", 32'(char_X), 0);

      // Blocked pixel at (250,400) stops a rightward walk at 249.
      do_reset();
      blk[400 * MAP_W + 250] = 1'b1;
      repeat (8) run_tick(K_RIGHT, 1'b0);
      check("blocked_x", 32'(char_X), 249);

      // Full jump: 48 up-steps, fall back, land.
      run_tick(K_UP, 1'b1);
      check("jump_start", 32'(jumping), 1);
      repeat (JUMP_LEN) run_tick(K_NONE, 1'b0);
      check("jump_apex_y", 32'(char_Y), 352);
      check("jump_apex_fall", 32'(jumping | on_ground), 0);
      repeat (JUMP_LEN) run_tick(K_NONE, 1'b0);
      check("fall_back_y", 32'(char_Y), 400);
      check("fall_not_landed", 32'(on_ground), 0);
      run_tick(K_NONE, 1'b0);
      check("landed", 32'(on_ground), 1);

      // Head bump on (244,395).
      do_reset();
      blk.delete();
      blk[395 * MAP_W + 244] = 1'b1;
      run_tick(K_UP, 1'b0);
      repeat (4) run_tick(K_NONE, 1'b0);
      check("bump_y", 32'(char_Y), 396);
      check("bump_still_jump", 32'(jumping), 1);
      run_tick(K_NONE, 1'b0);
      check("bump_hold_y", 32'(char_Y), 396);
      check("bump_to_fall", 32'(jumping), 0);
      repeat (5) run_tick(K_NONE, 1'b0);
      check("bump_landed", 32'(on_ground), 1);

      // Pause raised mid-evaluation: current tick completes, then nothing.
      mov = K_RIGHT;
      model_step(K_RIGHT);
      got = 0;
      for (int c = 0; c < 4 * TICK_DIV; c++) begin
         @(posedge sys_clk); #1;
         if (blk_rd) begin got = 1; break; end
      end
      check("pause_rd_seen", got, 1);
      pause = 1'b1;
      got = 0;
      for (int c = 0; c < 4 * TICK_DIV; c++) begin
         @(posedge sys_clk); #1;
         if (step_done) begin got = 1; break; end
      end
      check("pause_midseq_done", got, 1);
      compare_model();
      cnt = 0;
      for (int c = 0; c < 3 * TICK_DIV; c++) begin
         @(posedge sys_clk); #1;
         if (blk_rd || step_done) cnt++;
      end
      check("paused_activity", cnt, 0);
      pause = 1'b0;

      // Random keys over a scattered obstacle field.
      blk.delete();
      repeat (30) blk[int'($urandom_range(330, 400)) * MAP_W + int'($urandom_range(220, 270))] = 1'b1;
      for (int i = 0; i < 200; i++)
         run_tick(4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);

      // MEM_LAT=3 instance: sample point, then reset during WT_X.
      for (int c = 0; c < 4 * TICK_DIV; c++) begin
         @(posedge sys_clk); #1;
         if (step_done3) break;
      end
      mov3 = K_RIGHT;
      all_blk3 = 1'b1;
      rd_at = -1; done_at = -1;
      for (int c = 0; c < 4 * TICK_DIV; c++) begin
         @(posedge sys_clk); #1;
         if (blk_rd3 && rd_at < 0) rd_at = c;
         if (step_done3) begin done_at = c; break; end
      end
      check("lat3_done_latency", done_at - rd_at, 8);
      check("lat3_blocked_x", 32'(char_X3), 244);
      all_blk3 = 1'b0;
      got = 0;
      for (int c = 0; c < 4 * TICK_DIV; c++) begin
         @(posedge sys_clk); #1;
         if (step_done3) begin got = 1; break; end
      end
      check("lat3_free_done", got, 1);
      check("lat3_free_x", 32'(char_X3), 245);
      got = 0;
      for (int c = 0; c < 4 * TICK_DIV; c++) begin
         @(posedge sys_clk); #1;
         if (blk_rd3) begin got = 1; break; end
      end
      check("lat3_rd_seen", got, 1);
      @(posedge sys_clk); #1;
      rst3_n = 1'b0;
      #1;
      check("midrst_char_X", 32'(char_X3), X_INIT);
      check("midrst_char_Y", 32'(char_Y3), Y_INIT);
      check("midrst_blk_rd", 32'(blk_rd3), 0);
      check("midrst_blk_addr", 32'(blk_addr3), 0);
      check("midrst_on_ground", 32'(on_ground3), 1);
      check("midrst_jumping", 32'(jumping3), 0);
      check("midrst_step_done", 32'(step_done3), 0);
      @(negedge sys_clk);
      rst3_n = 1'b1;
      mov3 = K_NONE;
      cnt = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge sys_clk); #1;
         if (step_done3 || blk_rd3) cnt++;
      end
      check("midrst_discarded", cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
